n64_controller_rx: RTL and testbench
====================================

// Module: n64_controller_rx
// PURPOSE
//  Joybus receive stage for the emulated N64 controller: oversamples the console's data line,
//  decodes console command frames, then hands the line to n64_controller_tx.
//  Produces cmd, address and write-payload CRC, and drives cur_operation high for the Tx response.
//  Takes the line back on each rx_handoff toggle from Tx.
// PARAMETERS
//  LEVEL_WIDTH   2    sample_clk cycles per Joybus level (1 us); must match n64_controller_tx
//  MAX_LOW       5*LEVEL_WIDTH  longest legal low pulse in cycles; longer = frame error
//  IDLE_TIMEOUT  8*LEVEL_WIDTH  high cycles mid-frame before abort; also line-idle time for resync
// PORTS
//  sample_clk     in   1   sole clock; all state updates on posedge
//  reset_n        in   1   asynchronous, active-low reset
//  data_rx        in   1   raw Joybus line (async); 2-flop synchronised internally
//  rx_handoff     in   1   toggle from Tx; any change = Tx finished, Rx owns line again
//  cur_operation  out  1   0 = Rx owns line, 1 = Tx must respond
//  cmd            out  8   last received command byte
//  address        out  16  raw address field of cmd 0x02/0x03 (address CRC bits included)
//  crc            out  8   CRC-8 remainder over the 256 write-data bits, before the zero flush
//  wr_byte        out  8   write-payload byte, MSB first on wire
//  wr_byte_valid  out  1   1-cycle strobe; wr_byte valid
//  frame_error    out  1   1-cycle strobe; malformed frame discarded
// BEHAVIOUR
//  - Reset (async, reset_n=0): all outputs 0, state IDLE, counters and sync flops cleared.
//    Mid-frame reset drops the frame silently; no frame_error.
//  - All timing is on the synced line (2-cycle input latency).
//  - States:
//    - IDLE: wait for a falling edge; it clears bit_cnt and crc, then go to LOW.
//    - LOW: count low cycles from 1. Rising edge -> decode, go to HIGH.
//      low_cnt > MAX_LOW -> ERROR.
//    - HIGH: count high cycles. Falling edge -> LOW.
//      high_cnt == IDLE_TIMEOUT before the frame completes -> ERROR.
//    - HANDOFF: cur_operation=1; data_rx ignored. On rx_handoff != its registered copy:
//      cur_operation<=0 next cycle, go to IDLE.
//    - ERROR: frame_error pulses on entry. Wait for IDLE_TIMEOUT consecutive high cycles,
//      then IDLE. A falling edge restarts the wait count.
//  - Bit decode: low_cnt < 2*LEVEL_WIDTH -> '1' (L,H,H,H); otherwise -> '0' (L,L,L,H).
//    Bits shift in MSB first; bit_cnt increments on each decoded bit.
//  - Frame length, fixed by cmd once bit_cnt reaches 8:
//    - 0x00/0xFF/0x01 and unknown: 8 bits
//    - 0x02: 24 bits
//    - 0x03: 280 bits
//  - cmd loads on the 8th bit. address loads on bit 24 for 0x02/0x03; otherwise it holds.
//  - Stop bit: the low pulse when bit_cnt == frame length; accept any width <= MAX_LOW.
//    Its rising edge enters HANDOFF; cur_operation is 1 on the next cycle.
//    cmd, address and crc stay stable while in HANDOFF.
//  - Write payload (cmd 0x03, bits 24..279):
//    - Every 8th data bit presents wr_byte with a wr_byte_valid strobe in the same cycle.
//    - Each data bit also steps the serial CRC: poly 0x85, init 0x00, crc<={crc[6:0],0}^(crc[7]^bit ? 0x85:0).
//    - crc output is updated only when bit 279 is taken; it holds otherwise.
//  - A rx_handoff toggle while not in HANDOFF is absorbed: the registered copy updates, no other effect.
// STRUCTURE
//  - Shared package n64_joybus_pkg: LEVEL_WIDTH, command codes (INFO 0x00, STATUS 0x01, READ 0x02,
//    WRITE 0x03, RESET 0xFF), per-command frame lengths, CRC poly 0x85, rx state encoding.
//  - Sub-module joybus_bit_decoder: sync flops, low/high counters, edge detect.
//    Outputs bit_valid, bit_value, stop_edge, low_overrun and high_timeout.
//    The parent holds the frame FSM, shift registers and CRC.
// TESTING (LEVEL_WIDTH=2, one bit = 8 cycles)
//  1. Frame 0x00: eight bits of low 6/high 2, then stop low 2 -> cmd=0x00, cur_operation=1
//     after the stop rising edge, no wr_byte_valid.
//  2. Frame 0x01, then toggle rx_handoff -> cur_operation falls next cycle; a following 0x00 frame
//     decodes.
//  3. Frame 0x02 with address 0x8001 -> address=0x8001, cmd=0x02, cur_operation=1 after bit 24 + stop.
//  4. Frame 0x03, address 0x0000, 32 bytes of 0x00 -> 32 wr_byte_valid pulses with wr_byte=0x00,
//     crc=0x00. Repeat with byte 0 = 0x80 -> crc matches the bench model.
//  5. Low pulse of 12 cycles at bit 3 -> frame_error 1 cycle, cur_operation stays 0.
//     After 16 high cycles, a valid 0x00 frame is accepted.
//  6. reset_n low at bit 100 of a write -> all outputs 0 asynchronously.
//     After release, frame 0xFF decodes to cmd=0xFF, cur_operation=1.

Source files
------------

// File: rtl/n64_joybus_pkg.sv
// Shared Joybus definitions for the emulated N64 controller: timing, command codes,
// frame lengths, CRC polynomial and receive FSM encoding.
package n64_joybus_pkg;

    localparam int unsigned LEVEL_WIDTH = 2;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam int unsigned BIT_CNT_W = 9;

    localparam logic [BIT_CNT_W-1:0] LEN_CMD   = 9'd8;
    localparam logic [BIT_CNT_W-1:0] LEN_READ  = 9'd24;
    localparam logic [BIT_CNT_W-1:0] LEN_WRITE = 9'd280;

    localparam logic [7:0] CRC_POLY = 8'h85;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLow     = 3'd1,
        StHigh    = 3'd2,
        StHandoff = 3'd3,
        StError   = 3'd4
    } rx_state_e;

    function automatic logic [BIT_CNT_W-1:0] frame_len(input logic [7:0] code);
        logic [BIT_CNT_W-1:0] len;
        case (code)
            CMD_READ:  len = LEN_READ;
            CMD_WRITE: len = LEN_WRITE;
            default:   len = LEN_CMD;
        endcase
        return len;
    endfunction

    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic bit_in);
        return {crc_in[6:0], 1'b0} ^ ((crc_in[7] ^ bit_in) ? CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/joybus_bit_decoder.sv
// Joybus line front end: synchroniser, low/high pulse counters and edge detection.
// Classifies each low pulse into a data bit or a stop bit as directed by the frame FSM.
module joybus_bit_decoder #(
    parameter int unsigned LEVEL_WIDTH  = n64_joybus_pkg::LEVEL_WIDTH,
    parameter int unsigned MAX_LOW      = 5 * LEVEL_WIDTH,
    parameter int unsigned IDLE_TIMEOUT = 8 * LEVEL_WIDTH
) (
    input  logic sample_clk,
    input  logic reset_n,
    input  logic data_rx,
    input  logic expect_stop,
    output logic line_fall,
    output logic bit_valid,
    output logic bit_value,
    output logic stop_edge,
    output logic low_overrun,
    output logic high_timeout
);

    localparam int unsigned CNT_MAX = (MAX_LOW + 1 > IDLE_TIMEOUT) ? MAX_LOW + 1 : IDLE_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOW_SAT   = CNT_W'(MAX_LOW + 1);
    localparam logic [CNT_W-1:0] LOW_LIMIT = CNT_W'(MAX_LOW);
    localparam logic [CNT_W-1:0] HIGH_SAT  = CNT_W'(IDLE_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_LIMIT = CNT_W'(2 * LEVEL_WIDTH);

    logic [1:0]       sync_q;
    logic             line_prev_q;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic             line;
    logic             line_rise;

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            line_prev_q <= 1'b0;
            low_cnt_q   <= '0;
            high_cnt_q  <= '0;
        end else begin
            sync_q      <= {sync_q[0], data_rx};
            line_prev_q <= line;
            low_cnt_q   <= low_cnt_d;
            high_cnt_q  <= high_cnt_d;
        end
    end

    // Counters clear on the opposite level, so on the rising edge low_cnt_q still holds
    // the full width of the pulse that just ended.
    always_comb begin
        low_cnt_d  = low_cnt_q;
        high_cnt_d = high_cnt_q;
        if (line) begin
            low_cnt_d = '0;
            if (high_cnt_q != HIGH_SAT) begin
                high_cnt_d = high_cnt_q + 1'b1;
            end
        end else begin
            high_cnt_d = '0;
            if (low_cnt_q != LOW_SAT) begin
                low_cnt_d = low_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        line         = sync_q[1];
        line_fall    = line_prev_q & ~line;
        line_rise    = ~line_prev_q & line;
        low_overrun  = (low_cnt_q > LOW_LIMIT);
        high_timeout = (high_cnt_q >= HIGH_SAT);
        bit_value    = (low_cnt_q < ONE_LIMIT);
        bit_valid    = line_rise & ~expect_stop;
        stop_edge    = line_rise & expect_stop;
    end

endmodule

// File: rtl/n64_controller_rx.sv
// Joybus receive stage: decodes console command frames, captures cmd/address/write payload
// and CRC, then hands the line to the Tx stage until rx_handoff toggles.
module n64_controller_rx #(
    parameter int unsigned LEVEL_WIDTH  = n64_joybus_pkg::LEVEL_WIDTH,
    parameter int unsigned MAX_LOW      = 5 * LEVEL_WIDTH,
    parameter int unsigned IDLE_TIMEOUT = 8 * LEVEL_WIDTH
) (
    input  logic        sample_clk,
    input  logic        reset_n,
    input  logic        data_rx,
    input  logic        rx_handoff,
    output logic        cur_operation,
    output logic [7:0]  cmd,
    output logic [15:0] address,
    output logic [7:0]  crc,
    output logic [7:0]  wr_byte,
    output logic        wr_byte_valid,
    output logic        frame_error
);

    import n64_joybus_pkg::*;

    localparam logic [BIT_CNT_W-1:0] DATA_START = LEN_READ;

    rx_state_e            state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [15:0]          shift_q, shift_d;
    logic [7:0]           crc_acc_q, crc_acc_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [15:0]          address_q, address_d;
    logic [7:0]           crc_q, crc_d;
    logic [7:0]           wr_byte_q, wr_byte_d;
    logic                 wr_byte_valid_q, wr_byte_valid_d;
    logic                 frame_error_q, frame_error_d;
    logic                 cur_operation_q, cur_operation_d;
    logic                 handoff_q;

    logic line_fall, bit_valid, bit_value, stop_edge, low_overrun, high_timeout;
    logic expect_stop, handoff_toggle, take_bit, clear_frame;

    joybus_bit_decoder #(
        .LEVEL_WIDTH  (LEVEL_WIDTH),
        .MAX_LOW      (MAX_LOW),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_bit_decoder (
        .sample_clk   (sample_clk),
        .reset_n      (reset_n),
        .data_rx      (data_rx),
        .expect_stop  (expect_stop),
        .line_fall    (line_fall),
        .bit_valid    (bit_valid),
        .bit_value    (bit_value),
        .stop_edge    (stop_edge),
        .low_overrun  (low_overrun),
        .high_timeout (high_timeout)
    );

    // Length is only known once the command byte is in.
    assign expect_stop    = (bit_cnt_q >= LEN_CMD) && (bit_cnt_q == frame_len(cmd_q));
    assign handoff_toggle = rx_handoff ^ handoff_q;

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            crc_acc_q       <= '0;
            cmd_q           <= '0;
            address_q       <= '0;
            crc_q           <= '0;
            wr_byte_q       <= '0;
            wr_byte_valid_q <= 1'b0;
            frame_error_q   <= 1'b0;
            cur_operation_q <= 1'b0;
            handoff_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            crc_acc_q       <= crc_acc_d;
            cmd_q           <= cmd_d;
            address_q       <= address_d;
            crc_q           <= crc_d;
            wr_byte_q       <= wr_byte_d;
            wr_byte_valid_q <= wr_byte_valid_d;
            frame_error_q   <= frame_error_d;
            cur_operation_q <= cur_operation_d;
            handoff_q       <= rx_handoff;
        end
    end

    always_comb begin
        state_d     = state_q;
        take_bit    = 1'b0;
        clear_frame = 1'b0;
        case (state_q)
            StIdle: begin
                if (line_fall) begin
                    clear_frame = 1'b1;
                    state_d     = StLow;
                end
            end
            StLow: begin
                if (low_overrun) begin
                    state_d = StError;
                end else if (stop_edge) begin
                    state_d = StHandoff;
                end else if (bit_valid) begin
                    take_bit = 1'b1;
                    state_d  = StHigh;
                end
            end
            StHigh: begin
                if (high_timeout) begin
                    state_d = StError;
                end else if (line_fall) begin
                    state_d = StLow;
                end
            end
            StHandoff: begin
                if (handoff_toggle) begin
                    state_d = StIdle;
                end
            end
            StError: begin
                // A fall on the very cycle the idle wait completes starts a new frame.
                if (high_timeout) begin
                    if (line_fall) begin
                        clear_frame = 1'b1;
                        state_d     = StLow;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        crc_acc_d       = crc_acc_q;
        cmd_d           = cmd_q;
        address_d       = address_q;
        crc_d           = crc_q;
        wr_byte_d       = wr_byte_q;
        wr_byte_valid_d = 1'b0;

        if (clear_frame) begin
            bit_cnt_d = '0;
            crc_acc_d = '0;
        end

        if (take_bit) begin
            shift_d   = {shift_q[14:0], bit_value};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LEN_CMD - 1'b1) begin
                cmd_d = shift_d[7:0];
            end
            if ((bit_cnt_q == LEN_READ - 1'b1) && ((cmd_q == CMD_READ) || (cmd_q == CMD_WRITE))) begin
                address_d = shift_d;
            end
            if ((cmd_q == CMD_WRITE) && (bit_cnt_q >= DATA_START)) begin
                crc_acc_d = crc8_step(crc_acc_q, bit_value);
                if (bit_cnt_q[2:0] == 3'd7) begin
                    wr_byte_d       = shift_d[7:0];
                    wr_byte_valid_d = 1'b1;
                end
                if (bit_cnt_q == LEN_WRITE - 1'b1) begin
                    crc_d = crc_acc_d;
                end
            end
        end

        frame_error_d   = (state_d == StError) && (state_q != StError);
        cur_operation_d = (state_d == StHandoff);
    end

    assign cur_operation = cur_operation_q;
    assign cmd           = cmd_q;
    assign address       = address_q;
    assign crc           = crc_q;
    assign wr_byte       = wr_byte_q;
    assign wr_byte_valid = wr_byte_valid_q;
    assign frame_error   = frame_error_q;

endmodule

// File: tb/tb_n64_controller_rx.sv
// Directed bench for n64_controller_rx: drives Joybus frames and checks outputs every cycle
// against a frame-level model (expected cmd/address/CRC/payload bytes and handoff timing).
module tb_n64_controller_rx;

    import n64_joybus_pkg::*;

    logic        sample_clk = 1'b0;
    logic        reset_n;
    logic        data_rx;
    logic        rx_handoff;
    logic        cur_operation;
    logic [7:0]  cmd;
    logic [15:0] address;
    logic [7:0]  crc;
    logic [7:0]  wr_byte;
    logic        wr_byte_valid;
    logic        frame_error;

    n64_controller_rx #(
        .LEVEL_WIDTH  (2),
        .MAX_LOW      (10),
        .IDLE_TIMEOUT (16)
    ) dut (
        .sample_clk    (sample_clk),
        .reset_n       (reset_n),
        .data_rx       (data_rx),
        .rx_handoff    (rx_handoff),
        .cur_operation (cur_operation),
        .cmd           (cmd),
        .address       (address),
        .crc           (crc),
        .wr_byte       (wr_byte),
        .wr_byte_valid (wr_byte_valid),
        .frame_error   (frame_error)
    );

    always #5 sample_clk = ~sample_clk;

    int cyc = 0;
    always @(posedge sample_clk) cyc <= cyc + 1;

    // Model state
    int          passes = 0;
    int          total = 0;
    int          op_on = -1;
    int          op_off = -1;
    logic [7:0]  m_cmd = 8'h00;
    logic [15:0] m_addr = 16'h0000;
    logic [7:0]  m_crc = 8'h00;
    logic [7:0]  exp_bytes[$];
    logic [7:0]  payload[32];
    int          err_cycles = 0;
    int          wr_cnt = 0;
    int          wr_mark;
    logic        eo;
    bit          pin_msg[$];
    logic [7:0]  pin_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CRC as the remainder of msg(x)*x^8 divided by x^8+x^7+x^2+1, by long division.
    function automatic logic [7:0] model_crc(input bit msg[$]);
        bit         d[$];
        logic [8:0] g;
        logic [7:0] r;
        g = 9'h185;
        d = msg;
        for (int i = 0; i < 8; i++) d.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++) begin
            if (d[i]) begin
                for (int j = 0; j < 9; j++) d[i + j] = d[i + j] ^ g[8 - j];
            end
        end
        for (int j = 0; j < 8; j++) r[7 - j] = d[msg.size() + j];
        return r;
    endfunction

    function automatic logic exp_op_now();
        return (op_on >= 0) && (cyc >= op_on) && !((op_off >= op_on) && (cyc >= op_off));
    endfunction

    always @(negedge sample_clk) begin
        eo = exp_op_now();
        check("cur_operation", {31'd0, cur_operation}, {31'd0, eo});
        if (eo) begin
            check("cmd", {24'd0, cmd}, {24'd0, m_cmd});
            check("address", {16'd0, address}, {16'd0, m_addr});
            check("crc", {24'd0, crc}, {24'd0, m_crc});
        end
        if (wr_byte_valid) begin
            wr_cnt++;
            if (exp_bytes.size() == 0) begin
                check("wr_byte_valid_unexpected", {31'd0, wr_byte_valid}, 32'd0);
            end else begin
                check("wr_byte", {24'd0, wr_byte}, {24'd0, exp_bytes.pop_front()});
            end
        end
        if (frame_error) err_cycles++;
    end

    task automatic seg(input logic v, input int n);
        data_rx = v;
        repeat (n) begin
            @(posedge sample_clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            seg(1'b0, 2);
            seg(1'b1, 6);
        end else begin
            seg(1'b0, 6);
            seg(1'b1, 2);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_stop();
        seg(1'b0, 2);
        op_on = cyc + 3;  // two sync flops plus the FSM register
        seg(1'b1, 8);
    endtask

    task automatic frame(input logic [7:0] c, input logic [15:0] a);
        bit msg[$];
        send_byte(c);
        if ((c == CMD_READ) || (c == CMD_WRITE)) begin
            send_byte(a[15:8]);
            send_byte(a[7:0]);
            m_addr = a;
        end
        if (c == CMD_WRITE) begin
            for (int i = 0; i < 32; i++) begin
                exp_bytes.push_back(payload[i]);
                for (int b = 7; b >= 0; b--) msg.push_back(payload[i][b]);
            end
            m_crc = model_crc(msg);
            for (int i = 0; i < 32; i++) send_byte(payload[i]);
        end
        m_cmd = c;
        send_stop();
    endtask

    task automatic release_line();
        rx_handoff = ~rx_handoff;
        op_off = cyc + 1;
        @(negedge sample_clk);
        check("handoff_hold", {31'd0, cur_operation}, 32'd1);
        @(negedge sample_clk);
        check("handoff_drop", {31'd0, cur_operation}, 32'd0);
        @(posedge sample_clk);
        #1;
        seg(1'b1, 8);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cur_operation"}, {31'd0, cur_operation}, 32'd0);
        check({tag, "_cmd"}, {24'd0, cmd}, 32'd0);
        check({tag, "_address"}, {16'd0, address}, 32'd0);
        check({tag, "_crc"}, {24'd0, crc}, 32'd0);
        check({tag, "_wr_byte"}, {24'd0, wr_byte}, 32'd0);
        check({tag, "_wr_byte_valid"}, {31'd0, wr_byte_valid}, 32'd0);
        check({tag, "_frame_error"}, {31'd0, frame_error}, 32'd0);
    endtask

    initial begin
        reset_n    = 1'b1;
        data_rx    = 1'b1;
        rx_handoff = 1'b0;
        #1 reset_n = 1'b0;
        #2 check_all_zero("reset");
        repeat (3) @(posedge sample_clk);
        #1 reset_n = 1'b1;
        seg(1'b1, 24);

        // Pin the CRC model: byte 0x80 alone leaves remainder 0x89.
        pin_byte = 8'h80;
        for (int b = 7; b >= 0; b--) pin_msg.push_back(pin_byte[b]);
        check("model_pin_crc_80", {24'd0, model_crc(pin_msg)}, 32'h89);

        // A toggle outside HANDOFF must be absorbed.
        rx_handoff = ~rx_handoff;
        seg(1'b1, 4);

        // 1: info command
        frame(CMD_INFO, 16'h0000);
        check("t1_cmd", {24'd0, cmd}, 32'h00);
        check("t1_cur_operation", {31'd0, cur_operation}, 32'd1);
        check("t1_no_wr_byte", wr_cnt, 0);
        release_line();

        // 2: status, handoff, then info again
        frame(CMD_STATUS, 16'h0000);
        check("t2_cmd", {24'd0, cmd}, 32'h01);
        release_line();
        frame(CMD_INFO, 16'h0000);
        check("t2_cmd_after", {24'd0, cmd}, 32'h00);
        release_line();

        // 3: read with address 0x8001
        frame(CMD_READ, 16'h8001);
        check("t3_address", {16'd0, address}, 32'h8001);
        check("t3_cmd", {24'd0, cmd}, 32'h02);
        release_line();

        // 4: write of all zeros, then byte 0 = 0x80
        for (int i = 0; i < 32; i++) payload[i] = 8'h00;
        wr_mark = wr_cnt;
        frame(CMD_WRITE, 16'h0000);
        check("t4_wr_pulses", wr_cnt - wr_mark, 32);
        check("t4_crc_zero", {24'd0, crc}, 32'h00);
        check("t4_address", {16'd0, address}, 32'h0000);
        release_line();
        payload[0] = 8'h80;
        wr_mark = wr_cnt;
        frame(CMD_WRITE, 16'h0000);
        check("t4b_wr_pulses", wr_cnt - wr_mark, 32);
        check("t4b_crc", {24'd0, crc}, {24'd0, m_crc});
        release_line();

        // 5: 12-cycle low at bit 3, 16 idle cycles, then a good frame
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        seg(1'b0, 12);
        seg(1'b1, 16);
        check("t5_frame_error_cycles", err_cycles, 1);
        check("t5_cur_operation", {31'd0, cur_operation}, 32'd0);
        frame(CMD_INFO, 16'h0000);
        check("t5_cmd", {24'd0, cmd}, 32'h00);
        release_line();

        // 6: reset 100 bits into a write, then a reset command
        for (int i = 0; i < 32; i++) payload[i] = 8'(8'h3C + i * 7);
        for (int i = 0; i < 9; i++) exp_bytes.push_back(payload[i]);
        send_byte(CMD_WRITE);
        send_byte(8'h12);
        send_byte(8'h34);
        for (int i = 0; i < 9; i++) send_byte(payload[i]);
        for (int b = 7; b >= 4; b--) send_bit(payload[9][b]);
        check("t6_partial_bytes_seen", exp_bytes.size(), 0);
        #2 reset_n = 1'b0;
        op_on  = -1;
        m_cmd  = 8'h00;
        m_addr = 16'h0000;
        m_crc  = 8'h00;
        exp_bytes.delete();
        #1 check_all_zero("t6_async_reset");
        data_rx = 1'b1;
        repeat (3) @(posedge sample_clk);
        #1 reset_n = 1'b1;
        seg(1'b1, 24);
        frame(CMD_RESET, 16'h0000);
        check("t6_cmd", {24'd0, cmd}, 32'hFF);
        check("t6_cur_operation", {31'd0, cur_operation}, 32'd1);
        release_line();

        seg(1'b1, 8);
        check("end_wr_bytes_drained", exp_bytes.size(), 0);
        check("end_frame_error_total", err_cycles, 1);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
